// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared hold-state type, counter sizing and default cycle constants
package btn_event_pkg;

    typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_t;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 50_000_000;
    localparam int DEF_REPEAT_CYC   = 10_000_000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/btn_event_channel.sv
// btn_event_channel: one button channel with synchroniser, debounce and hold/auto-repeat events
module btn_event_channel
    import btn_event_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

    logic s1_q, s2_q;
    logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
    hold_state_t state_q, state_d;
    logic level_q, level_d, press_q, press_d, release_q, release_d;
    logic long_q, long_d, repeat_q, repeat_d;
    logic differ, toggle;

    always_comb begin
        differ    = s2_q != level_q;
        toggle    = differ && (dcnt_q == DEB_LAST);
        dcnt_d    = (!differ || toggle) ? '0 : dcnt_q + CNT_W'(1);
        level_d   = level_q ^ toggle;
        press_d   = toggle && !level_q;
        release_d = toggle && level_q;
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        // a debounced edge overrides whatever the hold counter was about to do
        if (release_d) begin
            state_d = IDLE;
            hcnt_d  = '0;
        end else if (press_d) begin
            state_d = HELD;
            hcnt_d  = '0;
        end else if (state_q == HELD) begin
            long_d  = hcnt_q == LONG_LAST;
            state_d = long_d ? LONG : HELD;
            hcnt_d  = long_d ? '0 : hcnt_q + CNT_W'(1);
        end else if (state_q == LONG) begin
            repeat_d = (hcnt_q == REP_LAST) && repeat_en_i;
            hcnt_d   = (hcnt_q == REP_LAST) ? '0 : hcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_event_detector.sv
// button_event_detector: N_CH independent debounced button channels with press/release/long/repeat pulses
module button_event_detector
    import btn_event_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_event_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .btn_i      (btn_i[i]),
            .repeat_en_i(repeat_en_i[i]),
            .level_o    (level_o[i]),
            .press_o    (press_o[i]),
            .release_o  (release_o[i]),
            .long_o     (long_o[i]),
            .repeat_o   (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_button_event_detector.sv
// tb_button_event_detector: vector table for debounce timing plus an event scoreboard for hold/repeat/reset
module tb_button_event_detector;

    localparam int D  = 4;
    localparam int LC = 10;
    localparam int RC = 3;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [1:0] btn_i, repeat_en_i, level_o, press_o, release_o, long_o, repeat_o;
    logic [7:0] pulses;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit sb_on = 1'b0;

    typedef struct { int e; logic [7:0] m; } ev_t;
    typedef struct { logic [1:0] btn; logic [9:0] exp; } vec_t;
    ev_t exp_q[$];
    vec_t vecs[44];

    button_event_detector #(
        .N_CH(2), .DEBOUNCE_CYC(D), .LONG_CYC(LC), .REPEAT_CYC(RC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i), .repeat_en_i(repeat_en_i),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .repeat_o(repeat_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    assign pulses = {repeat_o, long_o, release_o, press_o};

    // pulse map: [1:0] press, [3:2] release, [5:4] long, [7:6] repeat
    always @(negedge clk_i) begin
        if (sb_on) begin
            if (exp_q.size() != 0 && exp_q[0].e == cyc) begin
                total++;
                if (pulses !== exp_q[0].m) begin
                    bad++;
                    $display("FAIL pulses @%0d got=%b want=%b", cyc, pulses, exp_q[0].m);
                end
                void'(exp_q.pop_front());
            end else if (pulses !== 8'h00) begin
                total++;
                bad++;
                $display("FAIL stray pulse @%0d got=%b want=00000000", cyc, pulses);
            end
        end
    end

    task automatic push(input int e, input logic [7:0] m);
        exp_q.push_back('{e, m});
    endtask

    task automatic wait_until(input int e);
        int n = 0;
        while (cyc < e && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain outstanding=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(negedge clk_i);
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({level_o, press_o, release_o, long_o, repeat_o} !== 10'b0) begin
            bad++;
            $display("FAIL %s got=%b want=0", name, {level_o, press_o, release_o, long_o, repeat_o});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k, p, l, c;
        logic b, lv, pr, rl;
        // clean press rows 0-19, bounce then stable press rows 20-43
        for (int j = 0; j < 44; j++) begin
            b  = (j < 9) || (j >= 20 && j < 28 && ((j - 20) % 4) < 2) || (j >= 28 && j < 36);
            lv = (j >= 5 && j < 14) || (j >= 33 && j < 41);
            pr = (j == 5) || (j == 33);
            rl = (j == 14) || (j == 41);
            vecs[j].btn = {1'b0, b};
            vecs[j].exp = {4'b0000, 1'b0, rl, 1'b0, pr, 1'b0, lv};
        end
        rst_i = 1'b1;
        btn_i = 2'b00;
        repeat_en_i = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        check_zero("reset_state");
        rst_i = 1'b0;
        for (int j = 0; j < 44; j++) begin
            btn_i = vecs[j].btn;
            @(posedge clk_i);
            @(negedge clk_i);
            total++;
            if ({repeat_o, long_o, release_o, press_o, level_o} !== vecs[j].exp) begin
                bad++;
                $display("FAIL vec%0d got=%b want=%b", j,
                         {repeat_o, long_o, release_o, press_o, level_o}, vecs[j].exp);
            end
        end
        repeat (4) @(negedge clk_i);
        sb_on = 1'b1;
        // long press with repeat, released so the fall lands 35 cycles after press
        repeat_en_i = 2'b01;
        btn_i = 2'b01;
        k = cyc + 1; p = k + D + 1; l = p + LC;
        push(p, 8'h01);
        push(l, 8'h10);
        for (int e = l + RC; e < p + 35; e += RC) push(e, 8'h40);
        push(p + 35, 8'h04);
        wait_until(p + 29);
        btn_i = 2'b00;
        drain();
        // repeat disabled, enabled at long+4 keeps the original phase
        repeat_en_i = 2'b00;
        btn_i = 2'b01;
        k = cyc + 1; p = k + D + 1; l = p + LC;
        push(p, 8'h01);
        push(l, 8'h10);
        for (int e = l + 6; e < l + 15; e += RC) push(e, 8'h40);
        push(l + 15, 8'h04);
        wait_until(l + 4);
        repeat_en_i = 2'b01;
        wait_until(l + 9);
        btn_i = 2'b00;
        drain();
        repeat_en_i = 2'b00;
        // both channels together
        btn_i = 2'b11;
        k = cyc + 1; p = k + D + 1; l = p + LC;
        push(p, 8'h03);
        push(l, 8'h30);
        push(p + 17, 8'h0C);
        wait_until(p + 11);
        btn_i = 2'b00;
        drain();
        // asynchronous reset in the LONG state, button kept held
        repeat_en_i = 2'b01;
        btn_i = 2'b01;
        k = cyc + 1; p = k + D + 1; l = p + LC;
        push(p, 8'h01);
        push(l, 8'h10);
        wait_until(l + 1);
        sb_on = 1'b0;
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_zero("async_reset_now");
        @(negedge clk_i);
        @(negedge clk_i);
        check_zero("async_reset_held");
        rst_i = 1'b0;
        c = cyc; p = c + D + 2; l = p + LC;
        push(p, 8'h01);
        push(l, 8'h10);
        push(l + RC, 8'h40);
        push(l + 6, 8'h04);
        sb_on = 1'b1;
        wait_until(l);
        btn_i = 2'b00;
        drain();
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
